// File: rtl/vga_dither_out.sv
// Registered VGA output stage: 2x2 ordered dither from 2-bit to 1-bit per channel,
// with optional per-frame pattern rotation and syncs delayed to stay aligned with colour.
module vga_dither_out #(
  parameter int TEMPORAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_n,
  input  logic       vsync_n,
  input  logic [5:0] rgb,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       i_dither_en,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic [2:0] o_rgb,
  output logic [1:0] o_frame
);

  localparam logic ROTATE = (TEMPORAL != 0);

  logic [1:0] frame;
  logic       vs_prev;
  logic       armed;
  logic       dith_q;
  logic       frame_edge;

  logic [5:0] s1_rgb;
  logic [1:0] s1_t;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_dith;

  logic       px;
  logic       py;
  logic [1:0] thr;
  logic       unused_pos;

  assign unused_pos = ^{hpos[9:1], vpos[9:1]};

  // armed blocks a false edge when vsync_n is already low as reset releases
  assign frame_edge = armed & vs_prev & ~vsync_n;

  assign px  = hpos[0] ^ (frame[0] & ROTATE);
  assign py  = vpos[0] ^ (frame[1] & ROTATE);
  assign thr = {px & py, px ^ py};

  function automatic logic dith_bit(input logic [1:0] c, input logic [1:0] t, input logic d);
    return d ? (c > t) : c[1];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame   <= 2'd0;
      vs_prev <= 1'b1;
      armed   <= 1'b0;
      dith_q  <= 1'b1;
    end else begin
      vs_prev <= vsync_n;
      armed   <= armed | vsync_n;
      if (frame_edge) begin
        frame  <= frame + 2'd1;
        dith_q <= i_dither_en;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_rgb  <= 6'd0;
      s1_t    <= 2'd0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_dith <= 1'b1;
    end else begin
      s1_rgb  <= rgb;
      s1_t    <= thr;
      s1_hs   <= hsync_n;
      s1_vs   <= vsync_n;
      s1_dith <= dith_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rgb     <= 3'd0;
      o_hsync_n <= 1'b1;
      o_vsync_n <= 1'b1;
    end else begin
      o_rgb     <= {dith_bit(s1_rgb[5:4], s1_t, s1_dith),
                    dith_bit(s1_rgb[3:2], s1_t, s1_dith),
                    dith_bit(s1_rgb[1:0], s1_t, s1_dith)};
      o_hsync_n <= s1_hs;
      o_vsync_n <= s1_vs;
    end
  end

  assign o_frame = frame;

endmodule
